prbs_gen_chk: RTL and testbench



---
 rtl/prbs_pkg.sv | 36 +++
 rtl/prbs_chk.sv | 137 +++++++++++++
 rtl/prbs_gen_chk.sv | 81 ++++++++
 tb/tb_prbs_gen_chk.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// Shared LFSR helpers, checker FSM encoding and default polynomial constants
// for the PRBS generator/checker.
package prbs_pkg;

    typedef logic chk_state_t;
    localparam chk_state_t ST_SEARCH = 1'b0;
    localparam chk_state_t ST_LOCKED = 1'b1;

    // Feedback masks for a left-shifting Fibonacci LFSR; the MSB tap is the polynomial degree.
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [7:0]  SEED_8  = 8'hFF;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [15:0] SEED_16 = 16'hFFFF;
    localparam logic [30:0] TAPS_31 = 31'h4800_0000;
    localparam logic [30:0] SEED_31 = 31'h7FFF_FFFF;

    function automatic logic [31:0] lfsr_step(input logic [31:0] state,
                                              input logic [31:0] taps,
                                              input int unsigned width);
        logic [31:0] mask;
        logic        fb;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        fb   = ^(state & taps & mask);
        return ((state << 1) | {31'd0, fb}) & mask;
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs_chk.sv
// Self-synchronising PRBS checker: acquires lock from the received stream,
// then compares against a free-running local LFSR and counts bit errors.
module prbs_chk
    import prbs_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
    parameter int unsigned      LOCK_CNT = 4,
    parameter int unsigned      LOSS_CNT = 3,
    parameter int unsigned      ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] chk_data,
    input  logic             chk_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int unsigned      MCW     = $clog2(LOCK_CNT + 1);
    localparam int unsigned      BCW     = $clog2(LOSS_CNT + 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    function automatic logic [ERR_W-1:0] sat_add(input logic [ERR_W-1:0] a,
                                                 input logic [5:0]       b);
        logic [ERR_W+5:0] s;
        s = {6'd0, a} + {{ERR_W{1'b0}}, b};
        if (s > {6'd0, ERR_MAX}) begin
            return ERR_MAX;
        end
        return s[ERR_W-1:0];
    endfunction

    chk_state_t       fsm_q, fsm_d;
    logic [MCW-1:0]   match_cnt_q, match_cnt_d, match_inc;
    logic [BCW-1:0]   bad_cnt_q, bad_cnt_d, bad_inc;
    logic             have_prev_q, have_prev_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d, err_base;
    logic             err_pulse_q, err_pulse_d;

    logic [WIDTH-1:0] data_step, prev_step, exp_step, diff;
    logic [5:0]       diff_bits;
    logic             match_ok, miss, lock_now, drop_now;

    assign data_step = WIDTH'(lfsr_step(32'(chk_data), 32'(TAPS), WIDTH));
    assign prev_step = WIDTH'(lfsr_step(32'(prev_q), 32'(TAPS), WIDTH));
    assign exp_step  = WIDTH'(lfsr_step(32'(exp_q), 32'(TAPS), WIDTH));
    assign diff      = chk_data ^ exp_q;
    assign diff_bits = popcount(32'(diff));
    assign match_inc = match_cnt_q + 1'b1;
    assign bad_inc   = bad_cnt_q + 1'b1;

    // An all-zero word is never a match, so the stuck-at-zero line cannot lock.
    assign match_ok  = have_prev_q && (chk_data == prev_step) && (chk_data != '0);
    assign miss      = (diff != '0);
    assign lock_now  = chk_valid && (fsm_q == ST_SEARCH) && match_ok &&
                       (match_inc == MCW'(LOCK_CNT));
    assign drop_now  = chk_valid && (fsm_q == ST_LOCKED) && miss &&
                       (bad_inc == BCW'(LOSS_CNT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= ST_SEARCH;
            match_cnt_q <= '0;
            bad_cnt_q   <= '0;
            have_prev_q <= 1'b0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            match_cnt_q <= match_cnt_d;
            bad_cnt_q   <= bad_cnt_d;
            have_prev_q <= have_prev_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    // prev/exp are only consulted once have_prev or LOCKED says they are meaningful.
    always_ff @(posedge clk) begin
        prev_q <= prev_d;
        exp_q  <= exp_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            ST_SEARCH: if (lock_now) fsm_d = ST_LOCKED;
            ST_LOCKED: if (drop_now) fsm_d = ST_SEARCH;
            default:   fsm_d = ST_SEARCH;
        endcase
    end

    always_comb begin
        match_cnt_d = match_cnt_q;
        bad_cnt_d   = bad_cnt_q;
        have_prev_d = have_prev_q;
        prev_d      = prev_q;
        exp_d       = exp_q;
        if (chk_valid) begin
            if (fsm_q == ST_SEARCH) begin
                match_cnt_d = match_ok ? match_inc : '0;
                prev_d      = chk_data;
                have_prev_d = 1'b1;
                if (lock_now) begin
                    exp_d       = data_step;
                    bad_cnt_d   = '0;
                    match_cnt_d = '0;
                end
            end else begin
                exp_d     = exp_step;
                bad_cnt_d = miss ? bad_inc : '0;
                if (drop_now) begin
                    bad_cnt_d   = '0;
                    match_cnt_d = '0;
                    have_prev_d = 1'b0;
                end
            end
        end
    end

    // A clear in the same cycle as an error wipes the old total but keeps the new word's bits.
    always_comb begin
        err_pulse_d = chk_valid && (fsm_q == ST_LOCKED) && miss;
        err_base    = err_clr ? '0 : err_cnt_q;
        err_cnt_d   = err_pulse_d ? sat_add(err_base, diff_bits) : err_base;
    end

    assign locked    = (fsm_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: rtl/prbs_gen_chk.sv
// PRBS generator (seed load, single-bit error injection) plus the checker
// for link and loopback testing.
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int unsigned      WIDTH    = 8,
    parameter logic [WIDTH-1:0] TAPS     = 8'hB8,
    parameter logic [WIDTH-1:0] SEED     = 8'hFF,
    parameter int unsigned      LOCK_CNT = 4,
    parameter int unsigned      LOSS_CNT = 3,
    parameter int unsigned      ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gen_en,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_value,
    input  logic             inj_err,
    output logic [WIDTH-1:0] gen_data,
    output logic             gen_valid,
    input  logic [WIDTH-1:0] chk_data,
    input  logic             chk_valid,
    input  logic             err_clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt
);

    logic [WIDTH-1:0] state_q, state_d, state_step;
    logic [WIDTH-1:0] gen_data_q, gen_data_d;
    logic             gen_valid_q, gen_valid_d;

    assign state_step = WIDTH'(lfsr_step(32'(state_q), 32'(TAPS), WIDTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SEED;
            gen_data_q  <= SEED;
            gen_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gen_data_q  <= gen_data_d;
            gen_valid_q <= gen_valid_d;
        end
    end

    // Injection only touches the emitted word, so the sequence itself stays intact.
    always_comb begin
        state_d     = state_q;
        gen_data_d  = gen_data_q;
        gen_valid_d = 1'b0;
        if (seed_load) begin
            state_d = (seed_value == '0) ? SEED : seed_value;
        end else if (gen_en) begin
            state_d     = state_step;
            gen_data_d  = state_step ^ {{(WIDTH-1){1'b0}}, inj_err};
            gen_valid_d = 1'b1;
        end
    end

    assign gen_data  = gen_data_q;
    assign gen_valid = gen_valid_q;

    prbs_chk #(
        .WIDTH    (WIDTH),
        .TAPS     (TAPS),
        .LOCK_CNT (LOCK_CNT),
        .LOSS_CNT (LOSS_CNT),
        .ERR_W    (ERR_W)
    ) u_chk (
        .clk       (clk),
        .rst       (rst),
        .chk_data  (chk_data),
        .chk_valid (chk_valid),
        .err_clr   (err_clr),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt)
    );

endmodule

// File: tb/tb_prbs_gen_chk.sv
// Scoreboard bench for prbs_gen_chk: directed stimulus pushes expected
// responses, a negedge monitor pops and compares them.
module tb_prbs_gen_chk;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, gen_en, seed_load, inj_err, chk_valid, err_clr;
    logic [7:0] seed_value, chk_data;
    logic [7:0] gen_data, gen_data4;
    logic       gen_valid, gen_valid4, locked, locked4, err_pulse, err_pulse4;
    logic [15:0] err_cnt;
    logic [3:0]  err_cnt4;

    prbs_gen_chk dut (
        .clk(clk), .rst(rst), .gen_en(gen_en), .seed_load(seed_load),
        .seed_value(seed_value), .inj_err(inj_err), .gen_data(gen_data),
        .gen_valid(gen_valid), .chk_data(chk_data), .chk_valid(chk_valid),
        .err_clr(err_clr), .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    prbs_gen_chk #(.ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .gen_en(gen_en), .seed_load(seed_load),
        .seed_value(seed_value), .inj_err(inj_err), .gen_data(gen_data4),
        .gen_valid(gen_valid4), .chk_data(chk_data), .chk_valid(chk_valid),
        .err_clr(err_clr), .locked(locked4), .err_pulse(err_pulse4), .err_cnt(err_cnt4)
    );

    typedef struct {
        int          cyc;
        int          tag;
        bit          c_gen;
        logic [7:0]  gdata;
        logic        gvalid;
        bit          c_chk;
        logic        lock;
        logic        pulse;
        logic [15:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] ref_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [15:0] sat15(input logic [15:0] v);
        return (v > 16'd15) ? 16'd15 : v;
    endfunction

    task automatic check(input string nm, input int tag, input logic [31:0] act,
                         input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s tag=%0d actual=0x%0h required=0x%0h", nm, tag, act, req);
        end
    endtask

    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            exp_t e;
            e = sbq.pop_front();
            if (e.c_gen) begin
                check("gen_data", e.tag, 32'(gen_data), 32'(e.gdata));
                check("gen_valid", e.tag, 32'(gen_valid), 32'(e.gvalid));
            end
            if (e.c_chk) begin
                check("locked", e.tag, 32'(locked), 32'(e.lock));
                check("err_pulse", e.tag, 32'(err_pulse), 32'(e.pulse));
                check("err_cnt", e.tag, 32'(err_cnt), 32'(e.cnt));
                check("locked_w4", e.tag, 32'(locked4), 32'(e.lock));
                check("err_pulse_w4", e.tag, 32'(err_pulse4), 32'(e.pulse));
                check("err_cnt_w4", e.tag, 32'(err_cnt4), 32'(sat15(e.cnt)));
            end
        end
    end

    task automatic exp_gen(input int tag, input logic [7:0] d, input logic v);
        exp_t e;
        e = '{cyc: cyc + 1, tag: tag, c_gen: 1'b1, gdata: d, gvalid: v,
              c_chk: 1'b0, lock: 1'b0, pulse: 1'b0, cnt: 16'd0};
        sbq.push_back(e);
    endtask

    task automatic exp_chk(input int tag, input logic l, input logic p, input logic [15:0] c);
        exp_t e;
        e = '{cyc: cyc + 1, tag: tag, c_gen: 1'b0, gdata: 8'd0, gvalid: 1'b0,
              c_chk: 1'b1, lock: l, pulse: p, cnt: c};
        sbq.push_back(e);
    endtask

    task automatic drive(input logic ge, input logic sl, input logic [7:0] sv,
                         input logic ie, input logic cv, input logic [7:0] cd,
                         input logic ec);
        @(negedge clk);
        gen_en = ge; seed_load = sl; seed_value = sv; inj_err = ie;
        chk_valid = cv; chk_data = cd; err_clr = ec;
    endtask

    // Loopback: the generator output is fed back into the checker, optionally corrupted.
    task automatic feed(input logic [7:0] corrupt, input logic inj, input logic clr);
        @(negedge clk);
        gen_en = 1'b1; seed_load = 1'b0; seed_value = 8'd0; inj_err = inj;
        err_clr = clr; chk_valid = gen_valid; chk_data = gen_data ^ corrupt;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog tag=0 actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] steps5 [5];
        logic [7:0] m;
        steps5 = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE1};

        rst = 1'b1; gen_en = 1'b0; seed_load = 1'b0; seed_value = 8'd0;
        inj_err = 1'b0; chk_valid = 1'b0; chk_data = 8'd0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        drive(0, 0, 8'h00, 0, 0, 8'h00, 0);
        exp_gen(1, 8'hFF, 1'b0);
        exp_chk(1, 1'b0, 1'b0, 16'd0);

        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 8'h00, 0, 0, 8'h00, 0);
            exp_gen(100 + i, steps5[i], 1'b1);
        end
        drive(0, 0, 8'h00, 0, 0, 8'h00, 0);
        exp_gen(106, 8'hE1, 1'b0);

        m = 8'hE1;
        for (int i = 5; i < 255; i++) begin
            m = ref_step(m);
            drive(1, 0, 8'h00, 0, 0, 8'h00, 0);
            exp_gen(200 + i, (i == 254) ? 8'hFF : m, 1'b1);
        end

        drive(0, 1, 8'h00, 0, 0, 8'h00, 0); exp_gen(500, 8'hFF, 1'b0);
        drive(1, 0, 8'h00, 0, 0, 8'h00, 0); exp_gen(501, 8'hFE, 1'b1);
        drive(1, 1, 8'h5A, 0, 0, 8'h00, 0); exp_gen(502, 8'hFE, 1'b0);
        drive(1, 0, 8'h00, 0, 0, 8'h00, 0); exp_gen(503, 8'hB4, 1'b1);
        drive(0, 0, 8'h00, 1, 0, 8'h00, 0); exp_gen(504, 8'hB4, 1'b0);
        drive(1, 0, 8'h00, 0, 0, 8'h00, 0); exp_gen(505, 8'h69, 1'b1);
        drive(0, 0, 8'h00, 0, 0, 8'h00, 0); exp_gen(506, 8'h69, 1'b0);

        // First feed carries no valid word; lock follows the 5th valid word.
        for (int i = 0; i < 6; i++) begin
            feed(8'h00, 0, 0);
            exp_chk(600 + i, (i == 5), 1'b0, 16'd0);
        end
        for (int i = 0; i < 1000; i++) begin
            feed(8'h00, 0, 0);
            exp_chk(1000 + i, 1'b1, 1'b0, 16'd0);
        end

        feed(8'h00, 1, 0); exp_chk(3000, 1'b1, 1'b0, 16'd0);
        feed(8'h00, 0, 0); exp_chk(3001, 1'b1, 1'b1, 16'd1);
        for (int i = 0; i < 3; i++) begin
            feed(8'h00, 0, 0); exp_chk(3002 + i, 1'b1, 1'b0, 16'd1);
        end
        feed(8'h0F, 0, 0); exp_chk(3100, 1'b1, 1'b1, 16'd5);
        feed(8'h00, 0, 0); exp_chk(3101, 1'b1, 1'b0, 16'd5);
        feed(8'h03, 0, 1); exp_chk(3200, 1'b1, 1'b1, 16'd2);
        feed(8'h00, 0, 0); exp_chk(3201, 1'b1, 1'b0, 16'd2);

        feed(8'h80, 0, 0); exp_chk(3300, 1'b1, 1'b1, 16'd3);
        feed(8'h80, 0, 0); exp_chk(3301, 1'b1, 1'b1, 16'd4);
        feed(8'h80, 0, 0); exp_chk(3302, 1'b0, 1'b1, 16'd5);
        for (int i = 0; i < 5; i++) begin
            feed(8'h00, 0, 0); exp_chk(3400 + i, (i == 4), 1'b0, 16'd5);
        end

        feed(8'hFF, 0, 0); exp_chk(3500, 1'b1, 1'b1, 16'd13);
        feed(8'h00, 0, 0); exp_chk(3501, 1'b1, 1'b0, 16'd13);
        feed(8'hFF, 0, 0); exp_chk(3502, 1'b1, 1'b1, 16'd21);
        feed(8'h00, 0, 0); exp_chk(3503, 1'b1, 1'b0, 16'd21);
        feed(8'hFF, 0, 0); exp_chk(3504, 1'b1, 1'b1, 16'd29);

        @(negedge clk);
        #2;
        rst = 1'b1; gen_en = 1'b0; inj_err = 1'b0; chk_valid = 1'b0;
        chk_data = 8'd0; err_clr = 1'b0;
        #1;
        check("async_rst_gen_data", 3600, 32'(gen_data), 32'h0000_00FF);
        check("async_rst_gen_valid", 3600, 32'(gen_valid), 32'd0);
        check("async_rst_locked", 3600, 32'(locked), 32'd0);
        check("async_rst_err_cnt", 3600, 32'(err_cnt), 32'd0);
        check("async_rst_err_cnt_w4", 3600, 32'(err_cnt4), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 8'h00, 0, 1, 8'h00, 0);
            exp_chk(3700 + i, 1'b0, 1'b0, 16'd0);
        end
        drive(0, 0, 8'h00, 0, 0, 8'h00, 0);

        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
        if (sbq.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain tag=0 actual=%0d pending required=0 pending", sbq.size());
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
